// File: rtl/universal_shift_register.sv
// universal_shift_register: parametrised shift/rotate/load register with word counter; parity via USR_PARITY_EN
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_enable,
  input  logic [2:0]       mode,
  input  logic             data_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             word_done,
  output logic             parity_out
);
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  logic [WIDTH-1:0] r_data;
  logic             r_serial;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic [WIDTH-1:0] w_next_data;
  logic             w_next_serial;
  logic [CNT_W-1:0] w_next_count;
  logic             w_next_done;
  logic             w_shift;
  logic             w_wrap;
  // next-state selection: clear beats any mode; reserved modes fall through to hold
  always_comb begin
    w_shift       = shift_enable && (mode == M_SHL || mode == M_SHR);
    w_wrap        = w_shift && r_count == CNT_W'(WIDTH - 1);
    w_next_data   = clear                                ? RESET_VALUE :
                    !shift_enable                        ? r_data :
                    mode == M_SHL                        ? {r_data[WIDTH-2:0], data_in} :
                    mode == M_SHR                        ? {data_in, r_data[WIDTH-1:1]} :
                    mode == M_ROL                        ? {r_data[WIDTH-2:0], r_data[WIDTH-1]} :
                    mode == M_ROR                        ? {r_data[0], r_data[WIDTH-1:1]} :
                    mode == M_LOAD                       ? load_data : r_data;
    w_next_serial = clear || !shift_enable               ? r_serial :
                    mode == M_SHL || mode == M_ROL       ? r_data[WIDTH-1] :
                    mode == M_SHR || mode == M_ROR       ? r_data[0] : r_serial;
    w_next_count  = clear || w_wrap                      ? '0 :
                    shift_enable && mode == M_LOAD       ? '0 :
                    w_shift                              ? r_count + CNT_W'(1) : r_count;
    w_next_done   = !clear && w_wrap;
  end
  // state registers; word_done is a single-cycle strobe following the WIDTH-th shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_serial <= 1'b0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_data   <= w_next_data;
      r_serial <= w_next_serial;
      r_count  <= w_next_count;
      r_done   <= w_next_done;
    end
  end
`ifdef USR_PARITY_EN
  logic r_parity;
  // parity tracks the value data_out takes on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_parity <= ^RESET_VALUE;
    else r_parity <= ^w_next_data;
  end
  assign parity_out = r_parity;
`else
  assign parity_out = 1'b0;
`endif
  assign data_out   = r_data;
  assign serial_out = r_serial;
  assign bit_count  = r_count;
  assign word_done  = r_done;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed and random checks against an arithmetic reference model
module tb_universal_shift_register;
  localparam int W = 8;
  localparam longint unsigned MASK = (64'd1 << W) - 1;
  logic clk = 0, reset = 1, clear = 0, shift_enable = 0, data_in = 0;
  logic [2:0] mode = 0;
  logic [W-1:0] load_data = 0;
  logic [W-1:0] data_out;
  logic serial_out, word_done, parity_out;
  logic [3:0] bit_count;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  longint unsigned m_data = 0;
  int m_cnt = 0;
  bit m_ser = 0, m_done = 0;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .shift_enable(shift_enable),
    .mode(mode), .data_in(data_in), .load_data(load_data), .data_out(data_out),
    .serial_out(serial_out), .bit_count(bit_count), .word_done(word_done),
    .parity_out(parity_out)
  );

  initial forever #5 clk = ~clk;

  function automatic bit exp_par(longint unsigned d);
`ifdef USR_PARITY_EN
    return ^(d & MASK);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: arithmetic view of the register, not bit slicing
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data = 0; m_ser = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (clear) begin
        m_data = 0; m_cnt = 0;
      end else if (shift_enable) begin
        if (mode == 1 || mode == 3) begin
          m_ser = m_data[W-1];
          m_data = ((m_data << 1) | (mode == 1 ? longint'(data_in) : (m_data >> (W - 1)))) & MASK;
        end else if (mode == 2 || mode == 4) begin
          m_ser = m_data[0];
          m_data = (m_data >> 1) | ((mode == 2 ? longint'(data_in) : (m_data & 1)) << (W - 1));
        end else if (mode == 5) begin
          m_data = longint'(load_data); m_cnt = 0;
        end
        if (mode == 1 || mode == 2) begin
          m_cnt++;
          if (m_cnt == W) begin m_cnt = 0; m_done = 1; end
        end
      end
    end
  end

  // cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out", data_out, m_data);
      chk("serial_out", serial_out, m_ser);
      chk("bit_count", bit_count, m_cnt);
      chk("word_done", word_done, m_done);
      chk("parity_out", parity_out, exp_par(m_data));
    end
  end

  task automatic op(input logic se, input logic [2:0] md, input logic di, input logic [W-1:0] ld, input logic cl);
    shift_enable = se; mode = md; data_in = di; load_data = ld; clear = cl;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] bits;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_data", data_out, 0);
    chk("rst_serial", serial_out, 0);
    chk("rst_count", bit_count, 0);
    chk("rst_done", word_done, 0);
    chk("rst_parity", parity_out, 0);
    chk_en = 1;
    bits = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      op(1, 3'b001, bits[7-i], 0, 0);
      if (i == 6) begin
        chk("t1_done_early", word_done, 0);
        chk("t1_count7", bit_count, 7);
      end
    end
    chk("t1_data", data_out, 8'hB2);
    chk("t1_done", word_done, 1);
    chk("t1_count", bit_count, 0);
    op(0, 3'b000, 0, 0, 0);
    chk("t1_done_drop", word_done, 0);
    op(1, 3'b101, 0, 8'hA5, 0);
    for (int i = 0; i < 3; i++) begin
      op(1, 3'b100, 0, 0, 0);
      chk("t2_nodone", word_done, 0);
    end
    chk("t2_data", data_out, 8'hB4);
    chk("t2_serial", serial_out, 1);
    chk("t2_count", bit_count, 0);
    op(1, 3'b101, 0, 8'h81, 0);
    op(1, 3'b010, 0, 0, 0);
    chk("t3_serial1", serial_out, 1);
    op(1, 3'b010, 0, 0, 0);
    chk("t3_serial2", serial_out, 0);
    chk("t3_data", data_out, 8'h20);
    chk("t3_count", bit_count, 2);
    op(1, 3'b101, 0, 8'h00, 0);
    repeat (4) op(1, 3'b001, 1, 0, 0);
    repeat (5) op(0, 3'b001, 1, 8'hFF, 0);
    chk("t4_hold_data", data_out, 8'h0F);
    chk("t4_hold_count", bit_count, 4);
    for (int i = 0; i < 4; i++) begin
      op(1, 3'b001, 0, 0, 0);
      if (i == 2) chk("t4_done_early", word_done, 0);
    end
    chk("t4_done", word_done, 1);
    chk("t4_data", data_out, 8'hF0);
    op(1, 3'b101, 0, 8'h00, 0);
    repeat (5) op(1, 3'b001, 1, 0, 0);
    chk("t5_pre_count", bit_count, 5);
    #2 reset = 1;
    #1;
    chk("t5_async_data", data_out, 0);
    chk("t5_async_count", bit_count, 0);
    @(posedge clk); #1 reset = 0;
    chk("t5_rst_done", word_done, 0);
    repeat (7) op(1, 3'b001, 1, 0, 0);
    op(1, 3'b001, 1, 0, 1);
    chk("t5_clr_done", word_done, 0);
    chk("t5_clr_count", bit_count, 0);
    chk("t5_clr_data", data_out, 0);
    op(0, 3'b000, 0, 0, 0);
    chk("t5_clr_done2", word_done, 0);
    op(1, 3'b101, 0, 8'h07, 0);
`ifdef USR_PARITY_EN
    chk("t6_par_load", parity_out, 1);
`else
    chk("t6_par_load", parity_out, 0);
`endif
    op(1, 3'b001, 1, 0, 0);
    chk("t6_data", data_out, 8'h0F);
    chk("t6_par_shift", parity_out, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) begin
        #3 reset = 1;
        @(posedge clk); #1 reset = 0;
      end else begin
        op($urandom_range(3) != 0, 3'($urandom_range(7)), 1'($urandom),
           8'($urandom), $urandom_range(15) == 0);
      end
    end
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
